itlb_ptw: RTL

Sv32 hardware page-table walker that services instruction/data TLB misses. It accepts a miss request carrying a VPN and access type, reads one or two PTEs from memory through a single-outstanding request/response port, and checks them against the Sv32 rules. It returns either a leaf PTE with its level for TLB refill, or a page fault. It sits between the ITLB miss path (initiator) and the memory/cache read port.

---
 rtl/itlb_ptw.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/itlb_ptw.sv
`default_nettype none
// ============================================================================
//  Module      : itlb_ptw
//  Description : Sv32 page-table walker for TLB misses; one or two PTE reads,
//                leaf/permission/A-D checks, returns leaf PTE or page fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module itlb_ptw #(
   parameter int MXLEN = 32,
   parameter int PA_W  = 34
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [MXLEN-1:0] satp_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [19:0]      req_vpn_i,
   input  logic [1:0]       req_acc_i,
   output logic             mem_req_valid_o,
   input  logic             mem_req_ready_i,
   output logic [PA_W-1:0]  mem_req_addr_o,
   input  logic             mem_rsp_valid_i,
   input  logic [MXLEN-1:0] mem_rsp_data_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [MXLEN-1:0] rsp_pte_o,
   output logic             rsp_level_o,
   output logic             rsp_fault_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_L1_REQ  = 3'd1,
      S_L1_WAIT = 3'd2,
      S_L0_REQ  = 3'd3,
      S_L0_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [19:0]      r_vpn;
   logic [1:0]       r_acc;
   logic [21:0]      r_root_ppn;
   logic [MXLEN-1:0] r_pte, w_pte_nxt;
   logic             r_level, w_level_nxt;
   logic             r_fault, w_fault_nxt;
   logic             r_drop, w_drop_nxt;

   logic             w_accept;
   logic [PA_W-1:0]  w_addr_l1, w_addr_l0;
   logic             w_v, w_r, w_w, w_x, w_a, w_d;
   logic             w_lvl, w_invalid, w_nonleaf, w_misalign, w_perm_ok, w_leaf_ok;
   logic             w_unused;

   assign w_unused = ^{satp_i[30:22]};
   assign w_accept = (r_state == S_IDLE) && req_valid_i;

   assign w_addr_l1 = PA_W'({r_root_ppn, 12'b0}) + PA_W'({r_vpn[19:10], 2'b00});
   assign w_addr_l0 = PA_W'({r_pte[31:10], 12'b0}) + PA_W'({r_vpn[9:0], 2'b00});

   assign w_v = mem_rsp_data_i[0];
   assign w_r = mem_rsp_data_i[1];
   assign w_w = mem_rsp_data_i[2];
   assign w_x = mem_rsp_data_i[3];
   assign w_a = mem_rsp_data_i[6];
   assign w_d = mem_rsp_data_i[7];

   assign w_lvl      = (r_state == S_L1_WAIT);
   assign w_invalid  = !w_v || (!w_r && w_w);
   assign w_nonleaf  = !w_r && !w_x;
   // A level-1 leaf must map a 4 MiB-aligned frame, so PPN[0] has to be zero.
   assign w_misalign = w_lvl && (mem_rsp_data_i[19:10] != 10'd0);
   assign w_perm_ok  = (r_acc == 2'b00) ? w_r : (r_acc == 2'b01) ? w_w : w_x;
   assign w_leaf_ok  = w_perm_ok && w_a && !((r_acc == 2'b01) && !w_d) && !w_misalign;

   always_comb begin
      w_state_nxt = r_state;
      w_pte_nxt   = r_pte;
      w_level_nxt = r_level;
      w_fault_nxt = r_fault;
      w_drop_nxt  = r_drop;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i && !flush_i) begin
               w_drop_nxt = 1'b0;
               if (!satp_i[31]) begin
                  w_state_nxt = S_DONE;
                  w_pte_nxt   = '0;
                  w_level_nxt = 1'b1;
                  w_fault_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_L1_REQ;
               end
            end
         end
         S_L1_REQ, S_L0_REQ: begin
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (mem_req_ready_i) begin
               w_state_nxt = (r_state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
            end
         end
         S_L1_WAIT, S_L0_WAIT: begin
            if (mem_rsp_valid_i) begin
               if (r_drop || flush_i) begin
                  w_state_nxt = S_IDLE;
                  w_drop_nxt  = 1'b0;
               end else if (w_invalid || (w_nonleaf && !w_lvl) || (!w_nonleaf && !w_leaf_ok)) begin
                  w_state_nxt = S_DONE;
                  w_pte_nxt   = '0;
                  w_level_nxt = w_lvl;
                  w_fault_nxt = 1'b1;
               end else if (w_nonleaf) begin
                  w_state_nxt = S_L0_REQ;
                  w_pte_nxt   = mem_rsp_data_i;
               end else begin
                  w_state_nxt = S_DONE;
                  w_pte_nxt   = mem_rsp_data_i;
                  w_level_nxt = w_lvl;
                  w_fault_nxt = 1'b0;
               end
            end else if (flush_i) begin
               // The response is still owed by memory; wait for it, then discard.
               w_drop_nxt = 1'b1;
            end
         end
         S_DONE: begin
            if (flush_i || rsp_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_vpn      <= '0;
         r_acc      <= '0;
         r_root_ppn <= '0;
         r_pte      <= '0;
         r_level    <= 1'b0;
         r_fault    <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pte   <= w_pte_nxt;
         r_level <= w_level_nxt;
         r_fault <= w_fault_nxt;
         r_drop  <= w_drop_nxt;
         if (w_accept) begin
            r_vpn      <= req_vpn_i;
            r_acc      <= req_acc_i;
            r_root_ppn <= satp_i[21:0];
         end
      end
   end

   assign req_ready_o     = (r_state == S_IDLE) && !rst_i;
   assign mem_req_valid_o = (r_state == S_L1_REQ) || (r_state == S_L0_REQ);
   assign mem_req_addr_o  = (r_state == S_L1_REQ) ? w_addr_l1 :
                            (r_state == S_L0_REQ) ? w_addr_l0 : '0;
   assign rsp_valid_o     = (r_state == S_DONE);
   assign rsp_pte_o       = (r_state == S_DONE) ? r_pte : '0;
   assign rsp_level_o     = (r_state == S_DONE) && r_level;
   assign rsp_fault_o     = (r_state == S_DONE) && r_fault;

endmodule
`default_nettype wire
